// File: rtl/pipe_scheduler.sv
// rtl/pipe_scheduler.sv - game tick divider plus sequenced spawn/scroll/wrap/score owner for pipe obstacles
// Optional PIPE_SCHED_STEP_EN: adds a step input that replaces the TICK_DIV divider as tick source.
module pipe_scheduler #(
  parameter int NUM_PIPES    = 4,
  parameter int SCREEN_W     = 160,
  parameter int PIPE_SPACING = 40,
  parameter int TICK_DIV     = 833333,
  parameter int GAP_MIN      = 10,
  parameter int GAP_MAX      = 70
) (
  input  logic                   CLOCK_50,
  input  logic                   resetn,
  input  logic                   start,
  input  logic                   collided,
`ifdef PIPE_SCHED_STEP_EN
  input  logic                   step,
`endif
  input  logic [8:0]             bird_x,
  output logic                   game_tick,
  output logic [9*NUM_PIPES-1:0] pipe_x,
  output logic [7*NUM_PIPES-1:0] pipe_y,
  output logic [NUM_PIPES-1:0]   pipe_active,
  output logic [9:0]             score,
  output logic                   running,
  output logic                   frozen
);

  localparam int         TW       = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int         SW       = (PIPE_SPACING > 1) ? $clog2(PIPE_SPACING + 1) : 1;
  localparam int         SPAN     = GAP_MAX - GAP_MIN;
  localparam logic [8:0] X_RELOAD = 9'(SCREEN_W);
  localparam logic [6:0] Y_RESET  = 7'(GAP_MIN);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FROZEN} state_t;

  state_t               state_q, state_d;
  logic [8:0]           x_q [NUM_PIPES];
  logic [8:0]           x_d [NUM_PIPES];
  logic [6:0]           y_q [NUM_PIPES];
  logic [6:0]           y_d [NUM_PIPES];
  logic [NUM_PIPES-1:0] act_q, act_d;
  logic [9:0]           score_q, score_d;
  logic [SW-1:0]        spawn_q, spawn_d;
  logic [7:0]           lfsr_q, lfsr_d;
  logic                 game_tick_q, game_tick_d;

  logic                 start_game;
  logic                 tick_fire;
  logic                 run_step;
  logic                 hit;
  logic                 placed;
  logic [5:0]           gap_r;
  logic [6:0]           gap;

  assign start_game = start && (state_q != S_RUN);
  assign run_step   = (state_q == S_RUN) && !collided && tick_fire;

`ifdef PIPE_SCHED_STEP_EN
  assign tick_fire = step;
`else
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;

  assign tick_fire = (tick_cnt_q == TW'(TICK_DIV - 1));

  // Divider only advances while running un-collided; a collision freezes it in place.
  always_comb begin
    tick_cnt_d = tick_cnt_q;
    if (start_game) begin
      tick_cnt_d = '0;
    end else if (state_q == S_RUN && !collided) begin
      tick_cnt_d = tick_fire ? '0 : tick_cnt_q + TW'(1);
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
    end
  end
`endif

  // Fold the 6-bit random value into the gap span so every value is usable.
  always_comb begin
    gap_r = lfsr_q[5:0];
    if (gap_r > 6'(SPAN)) begin
      gap = Y_RESET + {1'b0, gap_r - 6'(SPAN) - 6'd1};
    end else begin
      gap = Y_RESET + {1'b0, gap_r};
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_RUN;
      S_RUN:    if (collided) state_d = S_FROZEN;
      S_FROZEN: if (start) state_d = S_RUN;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    running = (state_q == S_RUN);
    frozen  = (state_q == S_FROZEN);
  end

  always_comb begin
    x_d         = x_q;
    y_d         = y_q;
    act_d       = act_q;
    score_d     = score_q;
    spawn_d     = spawn_q;
    game_tick_d = 1'b0;
    hit         = 1'b0;
    placed      = 1'b0;
    lfsr_d      = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    if (start_game) begin
      score_d  = '0;
      act_d    = '0;
      act_d[0] = 1'b1;
      spawn_d  = '0;
      for (int i = 0; i < NUM_PIPES; i++) begin
        x_d[i] = X_RELOAD;
      end
      y_d[0] = gap;
    end else if (run_step) begin
      game_tick_d = 1'b1;
      for (int i = 0; i < NUM_PIPES; i++) begin
        if (act_q[i]) begin
          if (x_q[i] == bird_x) hit = 1'b1;
          if (x_q[i] == 9'd0) begin
            x_d[i] = X_RELOAD;
            y_d[i] = gap;
          end else begin
            x_d[i] = x_q[i] - 9'd1;
          end
        end
      end
      if (hit && score_q != 10'h3FF) score_d = score_q + 10'd1;
      // Spawn timer parks once every slot is occupied.
      if (!(&act_q)) begin
        if (spawn_q == SW'(PIPE_SPACING - 1)) begin
          spawn_d = '0;
          for (int i = 0; i < NUM_PIPES; i++) begin
            if (!act_q[i] && !placed) begin
              placed   = 1'b1;
              act_d[i] = 1'b1;
              x_d[i]   = X_RELOAD;
              y_d[i]   = gap;
            end
          end
        end else begin
          spawn_d = spawn_q + SW'(1);
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_PIPES; i++) begin
        x_q[i] <= X_RELOAD;
        y_q[i] <= Y_RESET;
      end
      act_q       <= '0;
      score_q     <= '0;
      spawn_q     <= '0;
      lfsr_q      <= 8'hA5;
      game_tick_q <= 1'b0;
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      act_q       <= act_d;
      score_q     <= score_d;
      spawn_q     <= spawn_d;
      lfsr_q      <= lfsr_d;
      game_tick_q <= game_tick_d;
    end
  end

  for (genvar i = 0; i < NUM_PIPES; i++) begin : g_pack
    assign pipe_x[9*i +: 9] = x_q[i];
    assign pipe_y[7*i +: 7] = y_q[i];
  end

  assign pipe_active = act_q;
  assign score       = score_q;
  assign game_tick   = game_tick_q;

endmodule

// File: tb/tb_pipe_scheduler.sv
// tb/tb_pipe_scheduler.sv - randomized and directed bench for pipe_scheduler against a behavioural model
module tb_pipe_scheduler;

  localparam int NP      = 4;
  localparam int SCRW    = 160;
  localparam int SPACING = 40;
  localparam int TDIV    = 4;
  localparam int GMIN    = 10;
  localparam int GMAX    = 70;
  localparam int SPAN    = GMAX - GMIN;

  logic            clk = 1'b0;
  logic            resetn;
  logic            start;
  logic            collided;
  logic            step;
  logic [8:0]      bird_x;
  logic            game_tick;
  logic [9*NP-1:0] pipe_x;
  logic [7*NP-1:0] pipe_y;
  logic [NP-1:0]   pipe_active;
  logic [9:0]      score;
  logic            running;
  logic            frozen;

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;
  logic track  = 1'b0;

  always #5 clk = ~clk;

  pipe_scheduler #(
    .NUM_PIPES(NP), .SCREEN_W(SCRW), .PIPE_SPACING(SPACING),
    .TICK_DIV(TDIV), .GAP_MIN(GMIN), .GAP_MAX(GMAX)
  ) dut (
    .CLOCK_50(clk),
    .resetn(resetn),
    .start(start),
    .collided(collided),
`ifdef PIPE_SCHED_STEP_EN
    .step(step),
`endif
    .bird_x(bird_x),
    .game_tick(game_tick),
    .pipe_x(pipe_x),
    .pipe_y(pipe_y),
    .pipe_active(pipe_active),
    .score(score),
    .running(running),
    .frozen(frozen)
  );

  typedef struct packed {
    logic [1:0]           st;    // 0 idle, 1 run, 2 frozen
    logic [NP-1:0][8:0]   x;
    logic [NP-1:0][6:0]   y;
    logic [NP-1:0]        act;
    logic [9:0]           score;
    logic                 gt;
    logic [31:0]          tc;    // cycles since last tick
    logic [31:0]          sc;    // ticks since last spawn
    logic [7:0]           lfsr;
  } mdl_t;

  function automatic mdl_t model_reset();
    mdl_t n;
    n.st = 2'd0;
    for (int i = 0; i < NP; i++) begin
      n.x[i] = 9'(SCRW);
      n.y[i] = 7'(GMIN);
    end
    n.act = '0;
    n.score = '0;
    n.gt = 1'b0;
    n.tc = 0;
    n.sc = 0;
    n.lfsr = 8'hA5;
    return n;
  endfunction

  function automatic mdl_t model_next(input mdl_t m, input logic s_in, input logic c_in,
                                      input logic [8:0] bx, input logic stp);
    mdl_t n;
    int r, g;
    logic tick, hit, placed;
    n = m;
    n.gt = 1'b0;
    n.lfsr = {m.lfsr[6:0], ^(m.lfsr & 8'b1011_1000)};
    r = int'(m.lfsr) % 64;
    g = (r > SPAN) ? GMIN + (r - SPAN - 1) : GMIN + r;
    if (m.st != 2'd1) begin
      if (s_in) begin
        n.st = 2'd1;
        n.score = '0;
        n.act = '0;
        n.act[0] = 1'b1;
        for (int i = 0; i < NP; i++) n.x[i] = 9'(SCRW);
        n.y[0] = 7'(g);
        n.tc = 0;
        n.sc = 0;
      end
    end else if (c_in) begin
      n.st = 2'd2;
    end else begin
`ifdef PIPE_SCHED_STEP_EN
      tick = stp;
      n.tc = 0;
`else
      tick = (m.tc == TDIV - 1);
      n.tc = tick ? 0 : m.tc + 1;
`endif
      if (tick) begin
        n.gt = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < NP; i++) begin
          if (m.act[i]) begin
            if (m.x[i] == bx) hit = 1'b1;
            if (m.x[i] == 0) begin
              n.x[i] = 9'(SCRW);
              n.y[i] = 7'(g);
            end else begin
              n.x[i] = m.x[i] - 9'd1;
            end
          end
        end
        if (hit && m.score < 1023) n.score = m.score + 10'd1;
        if (m.act != '1) begin
          n.sc = m.sc + 1;
          if (n.sc == SPACING) begin
            n.sc = 0;
            placed = 1'b0;
            for (int i = 0; i < NP; i++) begin
              if (!m.act[i] && !placed) begin
                placed = 1'b1;
                n.act[i] = 1'b1;
                n.x[i] = 9'(SCRW);
                n.y[i] = 7'(g);
              end
            end
          end
        end
      end
    end
    return n;
  endfunction

  mdl_t m;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) m <= model_reset();
    else         m <= model_next(m, start, collided, bird_x, step);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if ({game_tick, running, frozen, pipe_active, score, pipe_x, pipe_y} !==
          {m.gt, m.st == 2'd1, m.st == 2'd2, m.act, m.score, m.x, m.y}) begin
        errors++;
        $display("FAIL outputs t=%0t got gt=%b run=%b frz=%b act=%b score=%0d x=%h y=%h want gt=%b run=%b frz=%b act=%b score=%0d x=%h y=%h",
                 $time, game_tick, running, frozen, pipe_active, score, pipe_x, pipe_y,
                 m.gt, m.st == 2'd1, m.st == 2'd2, m.act, m.score, m.x, m.y);
      end
      if (game_tick) begin
        for (int i = 0; i < NP; i++) begin
          if (pipe_active[i] && pipe_x[9*i +: 9] == 9'(SCRW)) begin
            checks++;
            if (pipe_y[7*i +: 7] < 7'(GMIN) || pipe_y[7*i +: 7] > 7'(GMAX)) begin
              errors++;
              $display("FAIL gap_range slot=%0d got=%0d want=[%0d,%0d]", i, pipe_y[7*i +: 7], GMIN, GMAX);
            end
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_ticks(input int n);
    int got, budget;
    got = 0;
    budget = n * (TDIV + 2) + 16;
    while (got < n && budget > 0) begin
`ifdef PIPE_SCHED_STEP_EN
      step = (budget % 2 == 0);
`endif
      @(negedge clk);
      budget--;
      if (track) bird_x = pipe_x[8:0];
      if (game_tick) got++;
    end
    step = 1'b0;
    check("tick_count", 64'(got), 64'(n));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int gt_seen;
    resetn = 1'b0; start = 1'b0; collided = 1'b0; step = 1'b0; bird_x = 9'd300;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    resetn = 1'b1;

    gt_seen = 0;
    for (int i = 0; i < 100; i++) begin
      bird_x = 9'($urandom_range(0, 170));
      collided = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      if (game_tick) gt_seen++;
    end
    collided = 1'b0;
    bird_x = 9'd300;
    check("idle_active", 64'(pipe_active), 64'd0);
    check("idle_score", 64'(score), 64'd0);
    check("idle_pipe_x", 64'(pipe_x), 64'({NP{9'd160}}));
    check("idle_no_tick", 64'(gt_seen), 64'd0);

    pulse_start();
    check("start_active", 64'(pipe_active), 64'b0001);
    check("start_x0", 64'(pipe_x[8:0]), 64'd160);
    check("start_running", 64'(running), 64'd1);
    wait_ticks(10);
    check("tick10_x0", 64'(pipe_x[8:0]), 64'd150);
    wait_ticks(30);
    check("tick40_active", 64'(pipe_active), 64'b0011);
    check("tick40_x1", 64'(pipe_x[17:9]), 64'd160);
    check("tick40_x0", 64'(pipe_x[8:0]), 64'd120);
    wait_ticks(80);
    check("tick120_active", 64'(pipe_active), 64'b1111);
    check("tick120_x3", 64'(pipe_x[35:27]), 64'd160);
    wait_ticks(40);
    check("tick160_active", 64'(pipe_active), 64'b1111);
    check("tick160_x0", 64'(pipe_x[8:0]), 64'd0);
    wait_ticks(1);
    check("wrap_x0", 64'(pipe_x[8:0]), 64'd160);
    check("wrap_y0_lo", 64'(pipe_y[6:0] >= 7'd10), 64'd1);
    check("wrap_y0_hi", 64'(pipe_y[6:0] <= 7'd70), 64'd1);

`ifdef PIPE_SCHED_STEP_EN
    collided = 1'b1;
    step = 1'b1;
`else
    repeat (TDIV - 1) @(negedge clk);
    collided = 1'b1;
`endif
    @(negedge clk);
    collided = 1'b0;
    step = 1'b0;
    check("collide_frozen", 64'(frozen), 64'd1);
    check("collide_no_tick", 64'(game_tick), 64'd0);
    check("collide_x0", 64'(pipe_x[8:0]), 64'd160);
    for (int i = 0; i < 20; i++) begin
      collided = ($urandom_range(0, 1) == 0);
      @(negedge clk);
    end
    collided = 1'b0;
    check("frozen_hold_x0", 64'(pipe_x[8:0]), 64'd160);
    check("frozen_hold", 64'(frozen), 64'd1);

    bird_x = 9'd100;
    pulse_start();
    check("restart_score", 64'(score), 64'd0);
    check("restart_active", 64'(pipe_active), 64'b0001);
    check("restart_x0", 64'(pipe_x[8:0]), 64'd160);
    wait_ticks(60);
    check("bird_pre_x0", 64'(pipe_x[8:0]), 64'd100);
    check("bird_pre_score", 64'(score), 64'd0);
    wait_ticks(1);
    check("bird_post_x0", 64'(pipe_x[8:0]), 64'd99);
    check("bird_post_score", 64'(score), 64'd1);

    track = 1'b1;
    wait_ticks(1030);
    track = 1'b0;
    check("score_saturate", 64'(score), 64'd1023);

    for (int i = 0; i < 4000; i++) begin
      bird_x = ($urandom_range(0, 3) == 0) ? pipe_x[8:0] : 9'($urandom_range(0, 170));
      collided = ($urandom_range(0, 399) == 0);
      start = ($urandom_range(0, 59) == 0);
`ifdef PIPE_SCHED_STEP_EN
      step = ($urandom_range(0, 2) == 0);
`endif
      @(negedge clk);
    end
    start = 1'b0; collided = 1'b0; step = 1'b0;

    pulse_start();
    track = 1'b1;
    wait_ticks(5);
    track = 1'b0;
    #1 resetn = 1'b0;
    #1;
    check("areset_active", 64'(pipe_active), 64'd0);
    check("areset_score", 64'(score), 64'd0);
    check("areset_running", 64'(running), 64'd0);
    check("areset_tick", 64'(game_tick), 64'd0);
    check("areset_pipe_x", 64'(pipe_x), 64'({NP{9'd160}}));
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

`ifdef PIPE_SCHED_STEP_EN
    pulse_start();
    wait_ticks(3);
    gt_seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (game_tick) gt_seen++;
    end
    check("step_no_extra_tick", 64'(gt_seen), 64'd0);
    check("step_x0", 64'(pipe_x[8:0]), 64'd157);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
